// File: rtl/imm_encoder_if.sv
// Request and response bundle for the immediate encoder.
// The master side builds requests and consumes words; the slave side is the encoder.
interface imm_encoder_if #(
    parameter int unsigned ERR_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, opcode, funct3, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, err_count
    );

    modport slave (
        input  in_valid, opcode, funct3, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, err_count
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs register fields and an immediate into an instruction word (inverse of imm decode),
// through one register stage and a small output FIFO.
module imm_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    imm_encoder_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 33;

    logic [31:0]      enc_word_c;
    logic             enc_err_c;
    logic             imm12_ok_c;
    logic             accept_c;

    logic             s1_valid;
    logic [31:0]      s1_word;
    logic             s1_err;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             push_c;
    logic             pop_c;

    logic [ERR_W-1:0] err_cnt;

    // Format-dependent field placement and immediate range check
    always_comb begin
        enc_word_c = '0;
        enc_err_c  = 1'b0;
        imm12_ok_c = (bus.imm[31:11] == '0) || (bus.imm[31:11] == '1);
        unique case (bus.opcode[6:5])
            2'b00: begin
                enc_word_c = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_err_c  = !imm12_ok_c;
            end
            2'b01, 2'b11: begin
                enc_word_c = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
                enc_err_c  = !imm12_ok_c;
            end
            2'b10: begin
                enc_word_c = {7'b0, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_err_c  = (bus.imm != '0);
            end
        endcase
    end

    assign accept_c = bus.in_valid && bus.in_ready;
    assign push_c   = s1_valid;
    assign pop_c    = bus.out_valid && bus.out_ready;

    // Stage 1 register and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_err   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_word <= enc_word_c;
                s1_err  <= enc_err_c;
                if (enc_err_c && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end

    // Circular output buffer; space is reserved at accept time so a push never overflows
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= {s1_err, s1_word};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.in_ready  = (fifo_count + CNT_W'(s1_valid)) < CNT_W'(DEPTH);
    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_err   = mem[rd_ptr][32];
    assign bus.out_instr = mem[rd_ptr][31:0];
    assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized scoreboard bench for imm_encoder with directed encoding, range,
// backpressure, throughput and reset scenarios.
module tb_imm_encoder;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ERR_W = 4;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imm_encoder_if #(.ERR_W(ERR_W)) bus ();

    imm_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] word;
        logic        err;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          model_errs = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    time         last_pop_time = 0;
    logic        hold_valid = 1'b0;
    logic [32:0] hold_val = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: word built by arithmetic field placement, error from signed value range
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        exp_t e;
        int   s;
        logic [31:0] w;
        s = int'($signed(imm));
        w = 32'(op) + 32'(f3) * 32'd4096 + 32'(rs1) * 32'd32768;
        case (op[6:5])
            2'b00: begin
                w = w + (imm % 32'd4096) * 32'h0010_0000 + 32'(rd) * 32'd128;
                e.err = (s < -2048) || (s > 2047);
            end
            2'b10: begin
                w = w + 32'(rs2) * 32'h0010_0000 + 32'(rd) * 32'd128;
                e.err = (imm != 0);
            end
            default: begin
                w = w + ((imm / 32'd32) % 32'd128) * 32'h0200_0000
                      + 32'(rs2) * 32'h0010_0000 + (imm % 32'd32) * 32'd128;
                e.err = (s < -2048) || (s > 2047);
            end
        endcase
        e.word = w;
        e.imm  = imm;
        return e;
    endfunction

    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        case (w[6:5])
            2'b00:        return {{20{w[31]}}, w[31:20]};
            2'b01, 2'b11: return {{20{w[31]}}, w[31:25], w[11:7]};
            default:      return 32'h0;
        endcase
    endfunction

    // Input monitor and output scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            model_errs = 0;
            hold_valid = 1'b0;
        end else begin
            check("err_count", 64'(bus.err_count), 64'(model_errs));
            if (hold_valid && bus.out_valid)
                check("head_stable", 64'({bus.out_err, bus.out_instr}), 64'(hold_val));
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.opcode, bus.funct3, bus.rd, bus.rs1, bus.rs2, bus.imm);
                sb.push_back(e);
                n_acc++;
                if (e.err && model_errs < ERR_MAX) model_errs++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 64'(bus.out_instr), 64'hDEAD_0000_0000);
                end else begin
                    e = sb.pop_front();
                    check("word", 64'(bus.out_instr), 64'(e.word));
                    check("err", 64'(bus.out_err), 64'(e.err));
                    if (!e.err) check("roundtrip", 64'(decode_imm(bus.out_instr)), 64'(e.imm));
                end
                n_pop++;
                last_pop_time = $time;
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            hold_val   = {bus.out_err, bus.out_instr};
        end
    end

    task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.rd     = rd;
        bus.rs1    = rs1;
        bus.rs2    = rs2;
        bus.imm    = imm;
    endtask

    task automatic rand_req(input bit allow_err);
        logic [1:0]  fmt;
        logic [11:0] t;
        logic [31:0] imm;
        int          bnd[4];
        bnd = '{-2048, 2047, 2048, -2049};
        fmt = 2'($urandom_range(0, 3));
        t   = 12'($urandom);
        imm = {{20{t[11]}}, t};
        if (fmt == 2'b10) begin
            imm = (allow_err && $urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
        end else begin
            case ($urandom_range(0, allow_err ? 6 : 4))
                4:       imm = 32'(bnd[$urandom_range(0, 1)]);
                5:       imm = 32'($urandom_range(2048, 100000));
                6:       imm = 32'(bnd[$urandom_range(2, 3)]);
                default: ;
            endcase
        end
        set_req({fmt, 5'($urandom)}, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    endtask

    // Hold in_valid until accepted, then drop it one edge later
    task automatic send();
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) check("send_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_valid;
        end
        if (!ok) check(name, 64'(0), 64'(1));
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.out_valid && (sb.size() == 0);
        end
        if (!ok) check("drain_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int  a0;
        int  p0;
        time t0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_req('0, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_instr", 64'(bus.out_instr), 64'(0));
        check("rst_out_err", 64'(bus.out_err), 64'(0));

        // I-type with exact latency
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        set_req(7'h03, 3'd2, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("i_accept", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("i_lat_edge1", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("i_lat_edge2", 64'(bus.out_valid), 64'(1));
        check("i_word", 64'(bus.out_instr), 64'h0000_0000_FFC1_2283);
        check("i_err", 64'(bus.out_err), 64'(0));

        // S-type at the positive boundary
        @(posedge clk); #1;
        set_req(7'h23, 3'd2, 5'd0, 5'd1, 5'd3, 32'h0000_07FF);
        send();
        wait_out("s_timeout");
        check("s_word", 64'(bus.out_instr), 64'h0000_0000_7E30_AFA3);
        check("s_decode", 64'(decode_imm(bus.out_instr)), 64'h0000_0000_0000_07FF);

        // Range errors: I-type 2048, then R-type imm=1
        @(posedge clk); #1;
        set_req(7'h03, 3'd0, 5'd1, 5'd1, 5'd0, 32'd2048);
        send();
        wait_out("ri_timeout");
        check("ri_err", 64'(bus.out_err), 64'(1));
        check("ri_imm_field", 64'(bus.out_instr[31:20]), 64'h800);
        check("ri_err_count", 64'(bus.err_count), 64'(1));
        @(posedge clk); #1;
        set_req(7'h53, 3'd0, 5'd4, 5'd6, 5'd7, 32'd1);
        send();
        wait_out("rr_timeout");
        check("rr_err", 64'(bus.out_err), 64'(1));
        check("rr_err_count", 64'(bus.err_count), 64'(2));
        wait_drain();

        // Backpressure: consumer stalled for 10 cycles
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        rand_req(1'b0);
        a0 = n_acc;
        p0 = n_pop;
        bus.in_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_accepts", 64'(n_acc - a0), 64'(DEPTH));
        check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        check("bp_pops", 64'(n_pop - p0), 64'(DEPTH));
        check("bp_ready_back", 64'(bus.in_ready), 64'(1));

        // Throughput: 20 back-to-back in-range requests
        @(posedge clk); #1;
        p0 = n_pop;
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            bit ok = 1'b0;
            rand_req(1'b0);
            bus.in_valid = 1'b1;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                ok = bus.in_ready;
            end
            if (!ok) check("tp_stall", 64'(0), 64'(1));
            if (i == 0) t0 = $time;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_drain();
        check("tp_pops", 64'(n_pop - p0), 64'(20));
        check("tp_span", 64'(last_pop_time - t0), 64'(21 * 10));

        // Reset with three words buffered
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(7'h03, 3'(i), 5'(i + 1), 5'd3, 5'd0, 32'd5000 + 32'(i));
            send();
        end
        repeat (2) @(negedge clk);
        check("mr_buffered", 64'(bus.out_valid), 64'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_out_valid", 64'(bus.out_valid), 64'(0));
        check("mr_err_count", 64'(bus.err_count), 64'(0));
        check("mr_in_ready", 64'(bus.in_ready), 64'(1));
        check("mr_out_instr", 64'(bus.out_instr), 64'(0));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("mr_no_stale", 64'(bus.out_valid), 64'(0));
        end

        // Random traffic with errors, random stalls and counter saturation
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rand_req(1'b1);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        check("final_queue_empty", 64'(sb.size()), 64'(0));
        check("final_err_sat", 64'(bus.err_count), 64'(model_errs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
